pu_accumulator: RTL and testbench

Downstream stage of the processing unit. Consumes the PU's registered 12-bit partial sums, accumulates a fixed number of them into one neuron result, compares the total against a threshold, and presents a saturated result with a valid/ready handshake. It lets a neuron with more than four inputs be computed over several PU passes.

---
 rtl/pu_accumulator_if.sv | 28 ++
 rtl/pu_accumulator.sv | 108 ++++++++++
 tb/tb_pu_accumulator.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pu_accumulator_if.sv
// Handshake and data bundle between the PU, the accumulator and its consumer.
// The master side drives partial sums and consumes results; the slave side is the accumulator.
interface pu_accumulator_if #(
  parameter int IN_W  = 12,
  parameter int ACC_W = 16,
  parameter int OUT_W = 8
);
  logic             clr;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_ready;
  logic [ACC_W-1:0] threshold;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_sum;
  logic             out_fire;
  logic             out_sat;

  modport master (
    output clr, in_valid, in_data, threshold, out_ready,
    input  in_ready, out_valid, out_sum, out_fire, out_sat
  );

  modport slave (
    input  clr, in_valid, in_data, threshold, out_ready,
    output in_ready, out_valid, out_sum, out_fire, out_sat
  );
endinterface

// File: rtl/pu_accumulator.sv
// Sums NUM_PARTIALS partial sums from the PU into one neuron result, then holds the
// saturated sum and the threshold comparison until the consumer takes it.
module pu_accumulator #(
  parameter int NUM_PARTIALS = 4,
  parameter int IN_W         = 12,
  parameter int ACC_W        = 16,
  parameter int OUT_W        = 8
) (
  input  logic           clk,
  input  logic           rst,
  pu_accumulator_if.slave bus
);
  typedef enum logic {ACC, HOLD} state_e;

  localparam int              CW       = $clog2(NUM_PARTIALS);
  localparam logic [CW-1:0]    LAST_CNT = CW'(NUM_PARTIALS - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [ACC_W-1:0] OUT_MAX  = ACC_W'((2 ** OUT_W) - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             clip_q, clip_d;
  logic [OUT_W-1:0] outSum_q, outSum_d;
  logic             outFire_q, outFire_d;
  logic             outSat_q, outSat_d;

  logic [ACC_W-1:0] accBase;
  logic [ACC_W:0]   rawSum;
  logic [ACC_W-1:0] satSum;
  logic             clipNext;

  // The first beat of a group starts from zero, so stale acc/clip never leak across groups.
  always_comb begin
    accBase  = (cnt_q == '0) ? '0 : acc_q;
    rawSum   = {1'b0, accBase} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.in_data};
    satSum   = rawSum[ACC_W] ? ACC_MAX : rawSum[ACC_W-1:0];
    clipNext = ((cnt_q != '0) && clip_q) || rawSum[ACC_W];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    clip_d    = clip_q;
    outSum_d  = outSum_q;
    outFire_d = outFire_q;
    outSat_d  = outSat_q;

    if (bus.clr) begin
      state_d = ACC;
      cnt_d   = '0;
      acc_d   = '0;
      clip_d  = 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (bus.in_valid) begin
            acc_d  = satSum;
            clip_d = clipNext;
            if (cnt_q == LAST_CNT) begin
              cnt_d     = '0;
              clip_d    = 1'b0;
              outSum_d  = (satSum > OUT_MAX) ? OUT_MAX[OUT_W-1:0] : satSum[OUT_W-1:0];
              outSat_d  = clipNext || (satSum > OUT_MAX);
              outFire_d = (satSum >= bus.threshold);
              state_d   = HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_d = ACC;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACC;
      cnt_q     <= '0;
      acc_q     <= '0;
      clip_q    <= 1'b0;
      outSum_q  <= '0;
      outFire_q <= 1'b0;
      outSat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      clip_q    <= clip_d;
      outSum_q  <= outSum_d;
      outFire_q <= outFire_d;
      outSat_q  <= outSat_d;
    end
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = outSum_q;
  assign bus.out_fire  = outFire_q;
  assign bus.out_sat   = outSat_q;
endmodule

// File: tb/tb_pu_accumulator.sv
// Randomized and directed bench for pu_accumulator: a group-level reference model feeds a
// scoreboard queue that a separate monitor drains whenever a result is presented.
module tb_pu_accumulator;
  localparam int NP    = 4;
  localparam int IN_W  = 12;
  localparam int ACC_W = 16;
  localparam int OUT_W = 8;

  typedef struct packed {
    logic [OUT_W-1:0] sum;
    logic             fire;
    logic             sat;
  } result_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pu_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  pu_accumulator #(.NUM_PARTIALS(NP), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  result_t     expQ[$];
  int unsigned group[$];
  bit          holding = 1'b0;
  int          checks  = 0;
  int          passes  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Whole-group reference: running sum clipped at the accumulator ceiling, then mapped to the output.
  function automatic result_t modelResult(input int unsigned thr);
    int unsigned acc = 0;
    bit          clip = 1'b0;
    result_t     r;
    foreach (group[i]) begin
      acc += group[i];
      if (acc > 65535) begin
        acc  = 65535;
        clip = 1'b1;
      end
    end
    r.sum  = (acc > 255) ? 8'd255 : acc[7:0];
    r.sat  = clip || (acc > 255);
    r.fire = (acc >= thr);
    return r;
  endfunction

  task automatic applyStimulus(input bit rstV, input bit clrV, input bit vV,
                               input int unsigned d, input bit rdyV);
    logic [31:0] dv;
    dv = d;
    @(negedge clk);
    rst          = rstV;
    bus.clr      = clrV;
    bus.in_valid = vV;
    bus.in_data  = dv[IN_W-1:0];
    bus.out_ready = rdyV;
    @(posedge clk);
    if (rstV || clrV) begin
      group.delete();
      holding = 1'b0;
    end else if (holding) begin
      if (rdyV) holding = 1'b0;
    end else if (vV) begin
      group.push_back(d);
      if (group.size() == NP) begin
        expQ.push_back(modelResult(bus.threshold));
        group.delete();
        holding = 1'b1;
      end
    end
    #1;
    checkOutput("in_ready", {31'd0, bus.in_ready}, {31'd0, !holding});
    checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, holding});
  endtask

  task automatic beat(input int unsigned d);
    applyStimulus(1'b0, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic idle(input bit rdy);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, rdy);
  endtask

  task automatic expectResult(input string name, input int unsigned s, input bit f, input bit st);
    checkOutput({name, "_sum"}, {24'd0, bus.out_sum}, s);
    checkOutput({name, "_fire"}, {31'd0, bus.out_fire}, {31'd0, f});
    checkOutput({name, "_sat"}, {31'd0, bus.out_sat}, {31'd0, st});
  endtask

  // Monitor: pops one expectation per presented result and holds it for the whole HOLD period.
  initial begin
    result_t cur;
    bit      prevValid = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (!prevValid) begin
          if (expQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_result: got out_valid=1, expected no pending result");
          end else begin
            cur = expQ.pop_front();
          end
        end
        checkOutput("mon_sum", {24'd0, bus.out_sum}, {24'd0, cur.sum});
        checkOutput("mon_fire", {31'd0, bus.out_fire}, {31'd0, cur.fire});
        checkOutput("mon_sat", {31'd0, bus.out_sat}, {31'd0, cur.sat});
      end
      prevValid = (bus.out_valid === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no finish, expected finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.threshold = '0;

    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);
    expectResult("reset", 0, 1'b0, 1'b0);

    bus.threshold = 16'd50;
    beat(10); beat(20); beat(30); beat(40);
    expectResult("basic", 100, 1'b1, 1'b0);
    idle(1'b1);

    bus.threshold = 16'd20000;
    for (int i = 0; i < NP; i++) beat(4095);
    expectResult("saturation", 255, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 7, 1'b0);
      expectResult("backpressure", 255, 1'b0, 1'b1);
    end
    idle(1'b1);
    bus.threshold = 16'd20;
    for (int i = 0; i < NP; i++) beat(7);
    expectResult("after_stall", 28, 1'b1, 1'b0);
    idle(1'b1);

    bus.threshold = 16'd5;
    beat(1); idle(1'b0); beat(2); idle(1'b0); idle(1'b0); beat(3); beat(4);
    expectResult("bubbles", 10, 1'b1, 1'b0);
    idle(1'b1);
    beat(5); beat(6);
    applyStimulus(1'b0, 1'b1, 1'b1, 9, 1'b0);
    for (int i = 0; i < NP; i++) beat(1);
    expectResult("after_clr", 4, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < NP; i++) beat(2);
    expectResult("after_rst", 8, 1'b1, 1'b0);
    idle(1'b1);

    bus.threshold = 16'd100;
    for (int i = 0; i < NP; i++) beat(25);
    expectResult("thr_equal", 100, 1'b1, 1'b0);
    idle(1'b1);
    bus.threshold = 16'd101;
    for (int i = 0; i < NP; i++) beat(25);
    bus.threshold = 16'd0;
    idle(1'b0); idle(1'b0);
    expectResult("thr_above_held", 100, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b1);

    for (int n = 0; n < 600; n++) begin
      bit          v, rdy, c, r;
      int unsigned d;
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      c   = ($urandom_range(0, 40) == 0);
      r   = ($urandom_range(0, 150) == 0);
      d   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 80) : $urandom_range(0, 4095);
      if ($urandom_range(0, 7) == 0) bus.threshold = 16'($urandom_range(0, 20000));
      applyStimulus(r, c, v, d, rdy);
    end

    idle(1'b1); idle(1'b1); idle(1'b1);
    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
